// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator at the head of the IF stage.
//
// Selects the next fetch address by priority:
//   flush > branch > pending branch > PC+INC.
// It drives a request handshake to instruction memory. A branch that arrives
// while fetch cannot advance is latched so that it is not lost. A redirect
// target that is not word-aligned is trapped to EXC_VEC.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active-low
//   stall           pipeline stall vector; only bit 0 (PC stage) is used
//   flush_i         exception/eret flush, highest priority
//   flushAddr_i     flush target
//   branchEnable_i  branch/jump taken (single-cycle pulse)
//   branchAddr_i    branch target
//   if_ack_i        imem accepted the request for pc_o this cycle
//   pc_o            current fetch address (registered)
//   if_req_o        fetch request valid for pc_o (registered, high only in RUN)
//   pending_o       a branch is latched and not yet applied (registered)
//   addrErr_o       one-cycle pulse: a misaligned target was trapped (registered)
module pc_gen #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = 32'h80000000,
  parameter logic [ADDR_W-1:0]  EXC_VEC   = 32'h80001180,
  parameter int unsigned        INC       = 4,
  parameter int unsigned        STALL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  flushAddr_i,
  input  logic               branchEnable_i,
  input  logic [ADDR_W-1:0]  branchAddr_i,
  input  logic               if_ack_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               if_req_o,
  output logic               pending_o,
  output logic               addrErr_o
);

  localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic                pending_q, pending_d;
  logic                addr_err_q, addr_err_d;
  logic                if_req_q, if_req_d;

  logic                stall_pc;
  logic                adv;
  logic                load;
  logic [ADDR_W-1:0]   target;

  assign stall_pc = stall[0];

  // Only the PC-stage stall bit matters here; the rest are deliberately ignored.
  generate
    if (STALL_W > 1) begin : g_unused_stall
      logic unused_stall;
      assign unused_stall = ^stall[STALL_W-1:1];
    end
  endgenerate

  // Fetch advances only when the request is out, not stalled, and accepted.
  assign adv = (state_q == ST_RUN) && !stall_pc && if_ack_i;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    pending_d   = pending_q;
    addr_err_d  = 1'b0;
    load        = 1'b0;
    target      = pc_q;

    // Request state machine. A flush does not alter these transitions.
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  state_d = stall_pc ? ST_HOLD : ST_RUN;
      ST_HOLD: state_d = stall_pc ? ST_HOLD : ST_RUN;
      default: state_d = ST_BOOT;
    endcase
    if_req_d = (state_d == ST_RUN);

    // Next-PC priority chain
    if (flush_i) begin
      // A branch in the same cycle is dropped, not latched.
      load      = 1'b1;
      target    = flushAddr_i;
      pending_d = 1'b0;
    end else if (branchEnable_i && adv) begin
      load      = 1'b1;
      target    = branchAddr_i;
      pending_d = 1'b0;
    end else if (branchEnable_i) begin
      // Newest branch wins; alignment is checked only when it is applied.
      pend_addr_d = branchAddr_i;
      pending_d   = 1'b1;
    end else if (pending_q && adv) begin
      load      = 1'b1;
      target    = pend_addr_q;
      pending_d = 1'b0;
    end else if (adv) begin
      pc_d = pc_q + INC_V;  // wraps modulo 2^ADDR_W silently
    end

    // A redirect target must be word-aligned; otherwise trap to EXC_VEC.
    if (load) begin
      if (target[1:0] != 2'b00) begin
        pc_d       = EXC_VEC;
        addr_err_d = 1'b1;
      end else begin
        pc_d = target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VEC;
      pend_addr_q <= '0;
      pending_q   <= 1'b0;
      addr_err_q  <= 1'b0;
      if_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
      pending_q   <= pending_d;
      addr_err_q  <= addr_err_d;
      if_req_q    <= if_req_d;
    end
  end

  assign pc_o      = pc_q;
  assign if_req_o  = if_req_q;
  assign pending_o = pending_q;
  assign addrErr_o = addr_err_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam logic [31:0] RESET_VEC = 32'h80000000;
  localparam logic [31:0] EXC_VEC   = 32'h80001180;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush_i;
  logic [31:0] flushAddr_i;
  logic        branchEnable_i;
  logic [31:0] branchAddr_i;
  logic        if_ack_i;
  logic [31:0] pc_o;
  logic        if_req_o;
  logic        pending_o;
  logic        addrErr_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: fetch is "requesting" after boot whenever the PC stage
  // was not stalled on the last edge; a redirect lands or traps on alignment.
  logic [31:0] m_pc;
  logic        m_req;
  logic        m_booted;
  logic        m_pend;
  logic [31:0] m_paddr;
  logic        m_err;

  pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush_i        (flush_i),
    .flushAddr_i    (flushAddr_i),
    .branchEnable_i (branchEnable_i),
    .branchAddr_i   (branchAddr_i),
    .if_ack_i       (if_ack_i),
    .pc_o           (pc_o),
    .if_req_o       (if_req_o),
    .pending_o      (pending_o),
    .addrErr_o      (addrErr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = RESET_VEC;
    m_req    = 1'b0;
    m_booted = 1'b0;
    m_pend   = 1'b0;
    m_paddr  = '0;
    m_err    = 1'b0;
  endtask

  task automatic model_redirect(input logic [31:0] t);
    if (t % 4 != 0) begin
      m_pc  = EXC_VEC;
      m_err = 1'b1;
    end else begin
      m_pc = t;
    end
  endtask

  task automatic model_edge(input logic s0, input logic fl, input logic [31:0] fa,
                            input logic br, input logic [31:0] ba, input logic ack);
    logic moving;
    moving = m_req && !s0 && ack;
    m_err  = 1'b0;
    if (fl) begin
      model_redirect(fa);
      m_pend = 1'b0;
    end else if (br && moving) begin
      model_redirect(ba);
      m_pend = 1'b0;
    end else if (br) begin
      m_pend  = 1'b1;
      m_paddr = ba;
    end else if (m_pend && moving) begin
      model_redirect(m_paddr);
      m_pend = 1'b0;
    end else if (moving) begin
      m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
    end
    m_req    = m_booted ? !s0 : 1'b1;
    m_booted = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},      pc_o,      m_pc);
    chk({tag, ".req"},     {31'd0, if_req_o},  {31'd0, m_req});
    chk({tag, ".pending"}, {31'd0, pending_o}, {31'd0, m_pend});
    chk({tag, ".err"},     {31'd0, addrErr_o}, {31'd0, m_err});
  endtask

  // One transaction: drive inputs, take one edge, compare 1 time unit later.
  task automatic step(input string tag, input logic [5:0] st, input logic fl,
                      input logic [31:0] fa, input logic br, input logic [31:0] ba,
                      input logic ack);
    stall          = st;
    flush_i        = fl;
    flushAddr_i    = fa;
    branchEnable_i = br;
    branchAddr_i   = ba;
    if_ack_i       = ack;
    @(posedge clk);
    model_edge(st[0], fl, fa, br, ba, ack);
    #1;
    $display("%s st=%b fl=%b br=%b ack=%b -> pc=%h req=%b pend=%b err=%b",
             tag, st[0], fl, br, ack, pc_o, if_req_o, pending_o, addrErr_o);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0;
    stall = '0; flush_i = 0; flushAddr_i = '0;
    branchEnable_i = 0; branchAddr_i = '0; if_ack_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // T1: boot then sequential fetch
    step("t1_boot", 6'd0, 0, 0, 0, 0, 1);
    chk("t1_boot_pc", pc_o, 32'h80000000);
    step("t1_a", 6'd0, 0, 0, 0, 0, 1);
    chk("t1_a_pc", pc_o, 32'h80000004);
    step("t1_b", 6'd0, 0, 0, 0, 0, 1);
    chk("t1_b_pc", pc_o, 32'h80000008);

    // T2: branch while stalled goes pending, applied once fetch advances
    step("t2_stall", 6'd1, 0, 0, 0, 0, 1);
    step("t2_br", 6'd1, 0, 0, 1, 32'h80000100, 1);
    chk("t2_pend", {31'd0, pending_o}, 32'd1);
    step("t2_unstall", 6'd0, 0, 0, 0, 0, 1);
    step("t2_apply", 6'd0, 0, 0, 0, 0, 1);
    chk("t2_pc", pc_o, 32'h80000100);

    // T3: flush and branch together, flush wins and branch is dropped
    step("t3", 6'd0, 1, 32'h80000380, 1, 32'h80000200, 1);
    chk("t3_pc", pc_o, 32'h80000380);
    step("t3_next", 6'd0, 0, 0, 0, 0, 1);
    chk("t3_next_pc", pc_o, 32'h80000384);

    // T4: flush while stalled with a pending branch
    step("t4_stall", 6'd1, 0, 0, 0, 0, 1);
    step("t4_br", 6'd1, 0, 0, 1, 32'h80000500, 0);
    step("t4_flush", 6'd1, 1, 32'h80000380, 0, 0, 1);
    chk("t4_pc", pc_o, 32'h80000380);
    chk("t4_req", {31'd0, if_req_o}, 32'd0);
    step("t4_release", 6'd0, 0, 0, 0, 0, 1);

    // T5: misaligned branch with advance traps to EXC_VEC for one cycle
    step("t5_br", 6'd0, 0, 0, 1, 32'h80000102, 1);
    chk("t5_pc", pc_o, 32'h80001180);
    chk("t5_err", {31'd0, addrErr_o}, 32'd1);
    step("t5_after", 6'd0, 0, 0, 0, 0, 0);
    chk("t5_err_clr", {31'd0, addrErr_o}, 32'd0);

    // T6: wrap around the top of the address space
    step("t6_flush", 6'd0, 1, 32'hFFFFFFFC, 0, 0, 1);
    step("t6_wrap", 6'd0, 0, 0, 0, 0, 1);
    chk("t6_pc", pc_o, 32'h00000000);

    // Async reset mid-stall with a pending branch, no clock edge involved
    step("t6_stall", 6'd1, 0, 0, 1, 32'h80000700, 0);
    rst = 1'b0;
    #2;
    model_reset();
    check_all("t6_async");
    chk("t6_async_pc", pc_o, 32'h80000000);
    rst = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [5:0]  st;
      logic        fl, br, ack;
      logic [31:0] fa, ba;
      st    = 6'($urandom);
      st[0] = ($urandom_range(0, 3) == 0);
      fl    = ($urandom_range(0, 11) == 0);
      br    = ($urandom_range(0, 4) == 0);
      ack   = ($urandom_range(0, 3) != 0);
      fa    = $urandom;
      ba    = $urandom;
      if ($urandom_range(0, 5) != 0) fa[1:0] = 2'b00;
      if ($urandom_range(0, 5) != 0) ba[1:0] = 2'b00;
      if ($urandom_range(0, 19) == 0) begin
        ba = 32'hFFFFFFFC;
        fa = 32'hFFFFFFF8;
      end
      step($sformatf("rnd%0d", i), st, fl, fa, br, ba, ack);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
